// File: rtl/dual_port_ram_param.sv
// True dual-port synchronous RAM with a post-reset clear sequencer, selectable
// same-port read-during-write behaviour, optional output register and a dual-write collision flag.
module dual_port_ram_param #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 14,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              w_en1,
  input  logic [DATA_W-1:0] data2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic              w_en2,
  output logic [DATA_W-1:0] q1,
  output logic [DATA_W-1:0] q2,
  output logic              ready,
  output logic              collision
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              ready_q, ready_d;
  logic              clr_we, run;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] rd1_d, rd2_d;
  logic [DATA_W-1:0] rd1_p0, rd2_p0;
  logic              coll_d, coll_q;
  logic              we1, we2;

  function automatic logic [DATA_W-1:0] rdw_pick(input logic              we,
                                                  input logic [DATA_W-1:0] wdata,
                                                  input logic [DATA_W-1:0] old);
    return (RDW_MODE != 0 && we) ? wdata : old;
  endfunction

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    clr_we    = 1'b0;
    run       = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        run     = 1'b1;
        ready_d = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt_q <= '0;
      ready_q   <= (CLR_ON_RST == 0);
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // Port 1 is written after port 2 so it wins a same-address dual write.
  assign we1 = run && w_en1 && !rst;
  assign we2 = run && w_en2 && !rst;

  always_ff @(posedge clk) begin
    if (clr_we && !rst) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      if (we2) mem[addr2] <= data2;
      if (we1) mem[addr1] <= data1;
    end
  end

  // Stage p0: array read; the other port always sees pre-write contents.
  always_comb begin
    rd1_d  = rdw_pick(w_en1, data1, mem[addr1]);
    rd2_d  = rdw_pick(w_en2, data2, mem[addr2]);
    coll_d = run && w_en1 && w_en2 && (addr1 == addr2);
  end

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      rd1_p0 <= '0;
      rd2_p0 <= '0;
      coll_q <= 1'b0;
    end else begin
      rd1_p0 <= rd1_d;
      rd2_p0 <= rd2_d;
      coll_q <= coll_d;
    end
  end

  // Stage p1: optional output register adding one cycle of read latency.
  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] rd1_p1, rd2_p1;
    always_ff @(posedge clk) begin
      if (rst) begin
        rd1_p1 <= '0;
        rd2_p1 <= '0;
      end else begin
        rd1_p1 <= rd1_p0;
        rd2_p1 <= rd2_p0;
      end
    end
    assign q1 = rd1_p1;
    assign q2 = rd2_p1;
  end else begin : g_noreg
    assign q1 = rd1_p0;
    assign q2 = rd2_p0;
  end

  assign ready     = ready_q;
  assign collision = coll_q;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Directed bench: small clear-sequencer instance plus read-first/latency-1 and write-first/latency-2 full-size instances.
module tb_dual_port_ram_param;

  logic        clk = 1'b0;
  logic        rst_s, rst_b;
  logic [15:0] data1, data2;
  logic [13:0] addr1, addr2;
  logic        w_en1, w_en2;

  logic [15:0] s_q1, s_q2, a_q1, a_q2, b_q1, b_q2;
  logic        s_rdy, s_col, a_rdy, a_col, b_rdy, b_col;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dual_port_ram_param #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(0), .CLR_ON_RST(1)) u_small (
    .clk(clk), .rst(rst_s),
    .data1(data1), .addr1(addr1[3:0]), .w_en1(w_en1),
    .data2(data2), .addr2(addr2[3:0]), .w_en2(w_en2),
    .q1(s_q1), .q2(s_q2), .ready(s_rdy), .collision(s_col));

  dual_port_ram_param #(.DATA_W(16), .ADDR_W(14), .RDW_MODE(0), .OUT_REG(0), .CLR_ON_RST(1)) u_rf (
    .clk(clk), .rst(rst_b),
    .data1(data1), .addr1(addr1), .w_en1(w_en1),
    .data2(data2), .addr2(addr2), .w_en2(w_en2),
    .q1(a_q1), .q2(a_q2), .ready(a_rdy), .collision(a_col));

  dual_port_ram_param #(.DATA_W(16), .ADDR_W(14), .RDW_MODE(1), .OUT_REG(1), .CLR_ON_RST(1)) u_wf (
    .clk(clk), .rst(rst_b),
    .data1(data1), .addr1(addr1), .w_en1(w_en1),
    .data2(data2), .addr2(addr2), .w_en2(w_en2),
    .q1(b_q1), .q2(b_q2), .ready(b_rdy), .collision(b_col));

  typedef struct {
    logic        w1;
    logic [13:0] a1;
    logic [15:0] d1;
    logic        w2;
    logic [13:0] a2;
    logic [15:0] d2;
    logic [15:0] e1q1, e1q2;
    logic [15:0] e2q1, e2q2;
    logic        ecol;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_en1 = 1'b0; w_en2 = 1'b0;
    data1 = '0;   data2 = '0;
    addr1 = '0;   addr2 = '0;
  endtask

  initial begin
    logic [15:0] p_q1, p_q2;
    int cnt;

    // row: w1 a1 d1 | w2 a2 d2 | read-first q1 q2 | write-first q1 q2 | collision
    tbl[0]  = '{1'b1, 14'd101,  16'd20000,  1'b1, 14'd102,   16'd20123, 16'd0,     16'd0,     16'd20000,  16'd20123, 1'b0};
    tbl[1]  = '{1'b0, 14'd102,  16'd0,      1'b0, 14'd101,   16'd0,     16'd20123, 16'd20000, 16'd20123,  16'd20000, 1'b0};
    tbl[2]  = '{1'b1, 14'd101,  16'd45,     1'b1, 14'd101,   16'd18,    16'd20000, 16'd20000, 16'd45,     16'd18,    1'b1};
    tbl[3]  = '{1'b0, 14'd101,  16'd0,      1'b0, 14'd101,   16'd0,     16'd45,    16'd45,    16'd45,     16'd45,    1'b0};
    tbl[4]  = '{1'b1, 14'd6754, 16'd233,    1'b0, 14'd6754,  16'd0,     16'd0,     16'd0,     16'd233,    16'd0,     1'b0};
    tbl[5]  = '{1'b0, 14'd6754, 16'd0,      1'b0, 14'd102,   16'd0,     16'd233,   16'd20123, 16'd233,    16'd20123, 1'b0};
    tbl[6]  = '{1'b1, 14'd200,  16'd7,      1'b1, 14'd201,   16'd9,     16'd0,     16'd0,     16'd7,      16'd9,     1'b0};
    tbl[7]  = '{1'b0, 14'd201,  16'd0,      1'b0, 14'd200,   16'd0,     16'd9,     16'd7,     16'd9,      16'd7,     1'b0};
    tbl[8]  = '{1'b0, 14'd101,  16'd0,      1'b1, 14'd101,   16'd5555,  16'd45,    16'd45,    16'd45,     16'd5555,  1'b0};
    tbl[9]  = '{1'b0, 14'd101,  16'd0,      1'b0, 14'd101,   16'd0,     16'd5555,  16'd5555,  16'd5555,   16'd5555,  1'b0};
    tbl[10] = '{1'b1, 14'd16383, 16'hBEEF,  1'b0, 14'd0,     16'd0,     16'd0,     16'd0,     16'hBEEF,   16'd0,     1'b0};
    tbl[11] = '{1'b0, 14'd0,    16'd0,      1'b0, 14'd16383, 16'd0,     16'd0,     16'hBEEF,  16'd0,      16'hBEEF,  1'b0};

    idle();
    rst_s = 1'b1;
    rst_b = 1'b1;
    repeat (2) tick();
    chk("rst_ready", 32'(s_rdy), 32'd0);
    chk("rst_q1",    32'(s_q1),  32'd0);
    chk("rst_q2",    32'(s_q2),  32'd0);
    chk("rst_col",   32'(s_col), 32'd0);
    chk("rst_ready_big", 32'(a_rdy), 32'd0);

    // Release reset with same-address dual writes pending: all must be ignored.
    rst_s = 1'b0;
    rst_b = 1'b0;
    w_en1 = 1'b1; addr1 = 14'd3; data1 = 16'd342;
    w_en2 = 1'b1; addr2 = 14'd3; data2 = 16'd77;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("clr_ready", 32'(s_rdy), (k == 16) ? 32'd1 : 32'd0);
      chk("clr_q1",    32'(s_q1),  32'd0);
      chk("clr_q2",    32'(s_q2),  32'd0);
      chk("clr_col",   32'(s_col), 32'd0);
    end

    idle();
    for (int i = 0; i < 16; i++) begin
      addr1 = 14'(i);
      addr2 = 14'(15 - i);
      tick();
      chk("clr_rd_q1", 32'(s_q1), 32'd0);
      chk("clr_rd_q2", 32'(s_q2), 32'd0);
    end

    w_en1 = 1'b1; addr1 = 14'd5; data1 = 16'd1234;
    tick();
    w_en1 = 1'b0;
    tick();
    chk("pre_rst_wr", 32'(s_q1), 32'd1234);

    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    repeat (7) tick();
    chk("midclr_busy", 32'(s_rdy), 32'd0);
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    cnt = 0;
    while (!s_rdy && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("midclr_edges", 32'(cnt), 32'd16);
    tick();
    chk("midclr_rd5", 32'(s_q1), 32'd0);

    cnt = 0;
    while (!(a_rdy && b_rdy) && cnt < 20000) begin
      tick();
      cnt++;
    end
    chk("big_ready_rf", 32'(a_rdy), 32'd1);
    chk("big_ready_wf", 32'(b_rdy), 32'd1);
    repeat (3) tick();

    p_q1 = '0;
    p_q2 = '0;
    for (int i = 0; i < 12; i++) begin
      w_en1 = tbl[i].w1; addr1 = tbl[i].a1; data1 = tbl[i].d1;
      w_en2 = tbl[i].w2; addr2 = tbl[i].a2; data2 = tbl[i].d2;
      tick();
      chk($sformatf("rf_q1[%0d]", i), 32'(a_q1), 32'(tbl[i].e1q1));
      chk($sformatf("rf_q2[%0d]", i), 32'(a_q2), 32'(tbl[i].e1q2));
      chk($sformatf("rf_col[%0d]", i), 32'(a_col), 32'(tbl[i].ecol));
      chk($sformatf("wf_col[%0d]", i), 32'(b_col), 32'(tbl[i].ecol));
      chk($sformatf("wf_q1[%0d]", i), 32'(b_q1), 32'(p_q1));
      chk($sformatf("wf_q2[%0d]", i), 32'(b_q2), 32'(p_q2));
      p_q1 = tbl[i].e2q1;
      p_q2 = tbl[i].e2q2;
    end
    idle();
    tick();
    chk("wf_q1_flush", 32'(b_q1), 32'(p_q1));
    chk("wf_q2_flush", 32'(b_q2), 32'(p_q2));
    chk("ready_hold", 32'(a_rdy), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
